pos_ring_tx_node: RTL



---
 rtl/pos_ring_tx_node_pkg.sv | 22 ++
 rtl/pos_ring_tx_node_fifo.sv | 45 ++++
 rtl/pos_ring_tx_node.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pos_ring_tx_node_pkg.sv
// Shared types for the position-ring transmit node: widths, ring packet, node state.
package pos_ring_tx_node_pkg;

  localparam int GLOBAL_CELL_ID_WIDTH = 4;
  localparam int GCID_WIDTH           = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int RING_HOP_WIDTH       = 4;
  localparam int POS_DATA_WIDTH       = 96;

  typedef struct packed {
    logic [POS_DATA_WIDTH-1:0] data;
    logic [GCID_WIDTH-1:0]     gcid;
    logic [RING_HOP_WIDTH-1:0] hops;
  } pos_ring_pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ring_tx_state_t;

endpackage

// File: rtl/pos_ring_tx_node_fifo.sv
// Local injection buffer: synchronous FIFO with full/empty flags; reset flushes the pointers.
module pos_ring_tx_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // a push into a full FIFO only lands when a pop frees the slot in the same cycle
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pos_ring_tx_node.sv
// Position-ring transmit/forward node: injects local positions, forwards upstream traffic,
// retires own packets after a lap. Optional starvation guard: POS_RING_TX_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | nothing sent since reset
// RUN   | local positions arriving, last not yet seen
// DRAIN | last seen; waiting for FIFO, output reg and outstanding count to empty
// DONE  | all own packets retired, o_done=1, forwarding continues
module pos_ring_tx_node
  import pos_ring_tx_node_pkg::*;
#(
  parameter logic [GCID_WIDTH-1:0] HOME_GCID    = '0,
  parameter int                    RING_LEN     = 4,
  parameter int                    DATA_WIDTH   = 96,
  parameter int                    FIFO_DEPTH   = 16,
  parameter int                    STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_local_valid,
  input  logic [DATA_WIDTH-1:0]     i_local_data,
  input  logic                      i_local_last,
  output logic                      o_local_ready,
  input  logic                      i_ring_valid,
  input  logic [DATA_WIDTH-1:0]     i_ring_data,
  input  logic [GCID_WIDTH-1:0]     i_ring_gcid,
  input  logic [RING_HOP_WIDTH-1:0] i_ring_hops,
  output logic                      o_ring_ready,
  output logic                      o_ring_valid,
  output logic [DATA_WIDTH-1:0]     o_ring_data,
  output logic [GCID_WIDTH-1:0]     o_ring_gcid,
  output logic [RING_HOP_WIDTH-1:0] o_ring_hops,
  input  logic                      i_ring_out_ready,
  output logic                      o_done
);

  localparam int                        OUT_W    = $clog2(RING_LEN * FIFO_DEPTH) + 1;
  localparam logic [OUT_W-1:0]          OUT_MAX  = '1;
  localparam logic [RING_HOP_WIDTH-1:0] HOP_LAST = RING_HOP_WIDTH'(RING_LEN - 1);

  ring_tx_state_t    state_q;
  ring_tx_state_t    state_d;
  logic [OUT_W-1:0]  outstanding;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_WIDTH:0] fifo_rd;
  logic              fifo_last_unused;
  logic              out_own;
  logic              local_xfer;
  logic              can_load;
  logic              is_retire;
  logic              fwd_req;
  logic              force_inj;
  logic              do_fwd;
  logic              do_inj;
  logic              drain_ok;

  assign o_local_ready    = !fifo_full;
  assign local_xfer       = i_local_valid && !fifo_full;
  assign fifo_last_unused = fifo_rd[DATA_WIDTH];

  pos_ring_tx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (local_xfer),
    .push_data ({i_local_last, i_local_data}),
    .pop       (do_inj),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign can_load  = !o_ring_valid || i_ring_out_ready;
  assign is_retire = i_ring_valid && (i_ring_hops == HOP_LAST);
  assign fwd_req   = i_ring_valid && !is_retire;

`ifdef POS_RING_TX_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign force_inj = (starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty;

  // counts consecutive forward wins over a waiting local packet; stalls hold the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       starve_cnt <= '0;
    else if (fifo_empty || do_inj)    starve_cnt <= '0;
    else if (do_fwd)                  starve_cnt <= starve_cnt + 1'b1;
  end
`else
  localparam int STARVE_LIMIT_UNUSED = STARVE_LIMIT;
  assign force_inj = 1'b0;
`endif

  assign do_fwd       = fwd_req && can_load && !force_inj;
  assign do_inj       = can_load && !fifo_empty && !do_fwd;
  assign o_ring_ready = is_retire || do_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ring_valid <= 1'b0;
      o_ring_data  <= '0;
      o_ring_gcid  <= '0;
      o_ring_hops  <= '0;
      out_own      <= 1'b0;
    end else if (do_fwd) begin
      o_ring_valid <= 1'b1;
      o_ring_data  <= i_ring_data;
      o_ring_gcid  <= i_ring_gcid;
      o_ring_hops  <= i_ring_hops + 1'b1;
      out_own      <= 1'b0;
    end else if (do_inj) begin
      o_ring_valid <= 1'b1;
      o_ring_data  <= fifo_rd[DATA_WIDTH-1:0];
      o_ring_gcid  <= HOME_GCID;
      o_ring_hops  <= '0;
      out_own      <= 1'b1;
    end else if (can_load) begin
      o_ring_valid <= 1'b0;
      out_own      <= 1'b0;
    end
  end

  // retires of packets injected before a reset are untracked, so the count floors at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({do_inj, is_retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_outstanding_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_inj && !is_retire && (outstanding == OUT_MAX)));

  assign drain_ok = fifo_empty && !(o_ring_valid && out_own) && (outstanding == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (local_xfer) state_d = i_local_last ? DRAIN : RUN;
      RUN:        if (local_xfer && i_local_last) state_d = DRAIN;
      DRAIN:      if (drain_ok) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign o_done = (state_q == DONE);

endmodule
